// File: rtl/conv45_window_scheduler_if.sv
// Read-side and result-stream signals of the 45-degree Gabor window scheduler.
// The master is the scheduler; the slave side is BRAM, window registers and downstream.
interface conv45_window_scheduler_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned CW     = 10
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              pix_valid;
  logic              pipe_en;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_x;
  logic [CW-1:0]     out_y;
  logic              out_last;

  modport master (
    output rd_en, rd_addr, pix_valid, pipe_en,
    output out_valid, out_x, out_y, out_last,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_addr, pix_valid, pipe_en,
    input  out_valid, out_x, out_y, out_last,
    output out_ready
  );
endinterface

// File: rtl/conv45_window_scheduler.sv
// Raster-scan frame sequencer: issues BRAM reads, tags each pixel with row/col,
// masks incomplete 5x5 windows and keeps a stallable valid pipeline to the result.
module conv45_window_scheduler #(
  parameter int unsigned IMG_W    = 516,
  parameter int unsigned IMG_H    = 516,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned KERNEL   = 5,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned CW       = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  conv45_window_scheduler_if.master bus
);

  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);
  localparam int unsigned NPIX   = IMG_W * IMG_H;
  localparam int unsigned MARGIN = KERNEL - 1;
  localparam int unsigned CTR    = (KERNEL - 1) / 2;
  localparam int unsigned NST    = PIPE_LAT;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   busy_q, done_q;

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Tag pipeline between the read stage and the output registers.
  logic             v_q     [NST];
  logic             ok_q    [NST];
  logic             last_q  [NST];
  logic [COL_W-1:0] col_t_q [NST];
  logic [ROW_W-1:0] row_t_q [NST];

  logic          out_valid_q;
  logic          out_last_q;
  logic [CW-1:0] out_x_q;
  logic [CW-1:0] out_y_q;

  logic stall_c;
  logic rd_en_c;
  logic last_rd_c;
  logic ok_c;
  logic last_c;
  logic any_v_c;
  logic fin_ok_c;

  assign stall_c   = out_valid_q & ~bus.out_ready;
  assign rd_en_c   = (state_q == S_RUN) & ~stall_c;
  assign last_rd_c = rd_en_c & (addr_q == ADDR_W'(NPIX - 1));

  assign ok_c   = (row_q >= ROW_W'(MARGIN)) & (col_q >= COL_W'(MARGIN));
  assign last_c = (row_q == ROW_W'(IMG_H - 1)) & (col_q == COL_W'(IMG_W - 1));

  assign fin_ok_c = v_q[NST-1] & ok_q[NST-1];

  always_comb begin : any_valid
    any_v_c = 1'b0;
    for (int i = 0; i < int'(NST); i++) begin
      any_v_c = any_v_c | v_q[i];
    end
  end

  // Next-state logic; DRAIN finishes once the final result leaves without stalling.
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (last_rd_c) state_d = S_DRAIN;
      S_DRAIN: if (!any_v_c && !stall_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_reg
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Raster counters; the address is a plain incrementer to avoid a multiplier.
  always_comb begin : cnt_next
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if ((state_q == S_IDLE) && start_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (rd_en_c) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        if (row_q != ROW_W'(IMG_H - 1)) begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin : cnt_reg
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  // Stage 0 captures every issued read, masked or not, so the line buffers fill.
  always_ff @(posedge clk or posedge rst) begin : tag_pipe
    if (rst) begin
      for (int i = 0; i < int'(NST); i++) begin
        v_q[i]     <= 1'b0;
        ok_q[i]    <= 1'b0;
        last_q[i]  <= 1'b0;
        col_t_q[i] <= '0;
        row_t_q[i] <= '0;
      end
    end else if (!stall_c) begin
      v_q[0]     <= rd_en_c;
      ok_q[0]    <= ok_c;
      last_q[0]  <= last_c;
      col_t_q[0] <= col_q;
      row_t_q[0] <= row_q;
      for (int i = 1; i < int'(NST); i++) begin
        v_q[i]     <= v_q[i-1];
        ok_q[i]    <= ok_q[i-1];
        last_q[i]  <= last_q[i-1];
        col_t_q[i] <= col_t_q[i-1];
        row_t_q[i] <= row_t_q[i-1];
      end
    end
  end

  // Result registers; coordinates only move for unmasked windows.
  always_ff @(posedge clk or posedge rst) begin : out_reg
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else if (!stall_c) begin
      out_valid_q <= fin_ok_c;
      out_last_q  <= fin_ok_c & last_q[NST-1];
      if (fin_ok_c) begin
        out_x_q <= CW'(col_t_q[NST-1]) - CW'(CTR);
        out_y_q <= CW'(row_t_q[NST-1]) - CW'(CTR);
      end
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr   = addr_q;
  assign bus.pix_valid = v_q[0];
  assign bus.pipe_en   = ~stall_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;

endmodule

// File: doc/conv45_window_scheduler.md
# conv45_window_scheduler

Frame sequencer for the 45° Gabor convolution datapath. It raster-scans a W×H pixel image out of BRAM one pixel per cycle and tags each pixel with its row and column. It masks border positions where the 5×5 window is incomplete and keeps a valid pipeline aligned with the window registers and the symmetric-sum/multiply stages. It sits between the image BRAM, the external line-buffer/window registers, and the convolution datapath, and presents a ready/valid result stream with back-pressure.

## Interface
- IMG_W, 516: image width in pixels (≥ KERNEL).
- IMG_H, 516: image height in pixels (≥ KERNEL).
- ADDR_W, 19: BRAM address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H.
- KERNEL, 5: window size; border margin is KERNEL−1 on the leading side.
- PIPE_LAT, 2: register stages from window registers to result, i.e. the sum stage plus the multiply/accumulate stage.
- CW, 10: width of the out_x/out_y coordinate outputs.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to process a frame; ignored unless in IDLE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the last result has been accepted.
- rd_en  out  1  BRAM read enable. BRAM read latency is 1, and the BRAM output holds while rd_en is low.
- rd_addr  out  ADDR_W  linear BRAM address row·IMG_W+col.
- pix_valid  out  1  BRAM data is present this cycle; the window registers shift on pix_valid & pipe_en.
- pipe_en  out  1  global advance enable for the window and datapath registers; equals ~stall.
- out_valid  out  1  result at the datapath output is a valid window.
- out_ready  in  1  downstream accepts the result.
- out_x, out_y  out  CW  window-centre column and row: col−2, row−2 of the newest pixel.
- out_last  out  1  qualifies the final valid result of the frame.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
  - IDLE → RUN on start.
  - RUN → DRAIN after the read of address IMG_W·IMG_H−1 is issued.
  - DRAIN → DONE when the valid pipeline holds no valid stage.
  - DONE → IDLE unconditionally after one cycle; done=1 only in DONE.
- stall = out_valid & ~out_ready. When stall is high:
  - rd_en is forced to 0;
  - the col/row counters, the tag pipeline and all valid stages hold;
  - pipe_en=0.
- Read counters:
  - col increments on every issued read;
  - col wraps IMG_W−1 → 0 and increments row at the same time;
  - row stops at IMG_H−1.
  - rd_addr is held in a separate incrementing register and is never computed by multiplication.
- The tag pipeline carries {row, col, window_ok, last} from the read stage through 1+PIPE_LAT stages.
  - window_ok = (row ≥ KERNEL−1) & (col ≥ KERNEL−1). Columns < KERNEL−1 span the wrap from the previous row and are masked.
  - last = (row == IMG_H−1) & (col == IMG_W−1).
- pix_valid = stage-1 valid. Stage-1 valid is set for every issued read, including masked positions, so that the line buffers fill.
- out_valid = final-stage valid & window_ok. Masked entries still occupy pipeline slots but never assert out_valid.
- Each frame produces (IMG_W−4)·(IMG_H−4) results.
- start while busy or in DONE has no effect.
- Reset values: state=IDLE. busy, done, rd_en, pix_valid, out_valid and out_last are 0. rd_addr, out_x and out_y are 0. All counters and valid stages are 0. pipe_en=1.
- Reset asserted mid-frame aborts immediately with no done pulse. The next start restarts the frame at address 0.

## Timing
- Cycle 0 is the first RUN cycle, immediately after the clock edge that samples start: rd_en=1, rd_addr=0.
- With no stalls, the read of linear index k is issued in cycle k. pix_valid for it is in cycle k+1, and its result is in cycle k+1+PIPE_LAT.
- The first out_valid is in cycle (KERNEL−1)·IMG_W+(KERNEL−1)+1+PIPE_LAT.
- The last read is in cycle IMG_W·IMG_H−1. The last out_valid/out_last is in cycle IMG_W·IMG_H+PIPE_LAT, and done is in cycle IMG_W·IMG_H+PIPE_LAT+1.
- Each stall cycle delays every subsequent event by exactly one cycle.
- Outputs hold their value across a stall.
- Back-to-back frames: start is accepted in the cycle after done. The minimum frame period is IMG_W·IMG_H+PIPE_LAT+3 cycles.

## Test plan
All scenarios use IMG_W=8, IMG_H=6, PIPE_LAT=2 and out_ready=1 unless noted.
- Basic frame: start pulse → rd_addr 0..47 on consecutive cycles. The first out_valid is in cycle 39 with out_x=2, out_y=2. Exactly 8 results are produced. out_last and out_valid are in cycle 50, done is in cycle 51, and busy is low from cycle 51.
- Masking: log every out_valid → coordinates are (2..5, 2..3) only, in raster order. There is no out_valid for col<4 or row<4 reads.
- Back-pressure: out_ready=0 for 3 cycles starting at the first out_valid → out_valid, out_x and out_y hold, and rd_en=0 and pipe_en=0 for those 3 cycles. No result is lost or duplicated, and done moves to cycle 54.
- Start while busy: pulse start in cycle 10 → no effect; the frame completes with timing identical to the basic frame.
- Reset mid-frame: assert rst in cycle 20 → all outputs are 0 immediately and there is no done pulse. A new start yields the basic-frame sequence from address 0.
- Back-to-back frames: start in the cycle after done → the second frame reproduces the basic-frame results and cycle offsets.
